// File: rtl/array_accumulate_stage_if.sv
// Blocking sync/notify stream bundle: one input word channel and one output word channel.
// The slave side is the accumulate stage; the master side is whoever feeds and drains it.
interface array_accumulate_stage_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] b_in;
    logic             b_in_sync;
    logic             b_in_notify;
    logic [WIDTH-1:0] b_out;
    logic             b_out_sync;
    logic             b_out_notify;

    modport master (
        output b_in, b_in_sync, b_out_sync,
        input  b_in_notify, b_out, b_out_notify
    );

    modport slave (
        input  b_in, b_in_sync, b_out_sync,
        output b_in_notify, b_out, b_out_notify
    );
endinterface

// File: rtl/array_accumulate_stage.sv
// Frame-reduce stage: reads DEPTH signed words, then offers their wrapped sum on b_out.
// Define ARRAY_ACC_MAX_EN to also emit the frame's signed maximum as a second word.
module array_accumulate_stage #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    array_accumulate_stage_if.slave      bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

`ifdef ARRAY_ACC_MAX_EN
    typedef enum logic [1:0] {
        READ      = 2'd0,
        WRITE_SUM = 2'd1,
        WRITE_MAX = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        READ      = 2'd0,
        WRITE_SUM = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_out_q, b_out_d;
    logic [WIDTH-1:0] data_buf_q [DEPTH];
    logic [WIDTH-1:0] data_buf_d [DEPTH];
`ifdef ARRAY_ACC_MAX_EN
    logic [WIDTH-1:0] max_q, max_d;
`endif

    // Handshake flags follow the state register directly, so they can never both be high.
    assign bus.b_in_notify  = (state_q == READ);
    assign bus.b_out_notify = (state_q != READ);
    assign bus.b_out        = b_out_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        b_out_d    = b_out_q;
        data_buf_d = data_buf_q;
`ifdef ARRAY_ACC_MAX_EN
        max_d      = max_q;
`endif
        case (state_q)
            READ: begin
                if (bus.b_in_sync) begin
                    data_buf_d[idx_q] = bus.b_in;
                    acc_d             = acc_q + bus.b_in;
`ifdef ARRAY_ACC_MAX_EN
                    // First element of a frame seeds the max regardless of its value.
                    if ((idx_q == '0) || ($signed(bus.b_in) > $signed(max_q))) begin
                        max_d = bus.b_in;
                    end
`endif
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        b_out_d = acc_q + bus.b_in;
                        state_d = WRITE_SUM;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WRITE_SUM: begin
                if (bus.b_out_sync) begin
                    acc_d = '0;
`ifdef ARRAY_ACC_MAX_EN
                    b_out_d = max_q;
                    state_d = WRITE_MAX;
`else
                    state_d = READ;
`endif
                end
            end
`ifdef ARRAY_ACC_MAX_EN
            WRITE_MAX: begin
                if (bus.b_out_sync) begin
                    state_d = READ;
                end
            end
`endif
            default: begin
                state_d = READ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= READ;
            idx_q   <= '0;
            acc_q   <= '0;
            b_out_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_buf_q[i] <= '0;
            end
`ifdef ARRAY_ACC_MAX_EN
            max_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            b_out_q    <= b_out_d;
            data_buf_q <= data_buf_d;
`ifdef ARRAY_ACC_MAX_EN
            max_q      <= max_d;
`endif
        end
    end
endmodule

// File: tb/tb_array_accumulate_stage.sv
// Directed self-checking bench for array_accumulate_stage (DEPTH=5, WIDTH=32).
// Honours ARRAY_ACC_MAX_EN by expecting the extra max word after each sum.
module tb_array_accumulate_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    array_accumulate_stage_if #(.WIDTH(32)) bus ();

    array_accumulate_stage #(
        .DEPTH (5),
        .WIDTH (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
    task automatic applyStimulus(input logic sync, input logic [31:0] data, input logic osync);
        bus.b_in_sync  = sync;
        bus.b_in       = data;
        bus.b_out_sync = osync;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic feedFrame(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] d3, input logic [31:0] d4);
        applyStimulus(1'b1, d0, 1'b0);
        applyStimulus(1'b1, d1, 1'b0);
        applyStimulus(1'b1, d2, 1'b0);
        applyStimulus(1'b1, d3, 1'b0);
        checkOutput("no_result_before_last", {31'd0, bus.b_out_notify}, 32'd0);
        applyStimulus(1'b1, d4, 1'b0);
    endtask

    task automatic checkSum(input string tag, input logic [31:0] expSum);
        checkOutput({tag, "_notify"}, {31'd0, bus.b_out_notify}, 32'd1);
        checkOutput({tag, "_in_notify"}, {31'd0, bus.b_in_notify}, 32'd0);
        checkOutput({tag, "_sum"}, bus.b_out, expSum);
    endtask

    task automatic acceptOutput(input string tag, input logic [31:0] expMax);
        applyStimulus(1'b0, 32'd0, 1'b1);
`ifdef ARRAY_ACC_MAX_EN
        checkOutput({tag, "_max"}, bus.b_out, expMax);
        checkOutput({tag, "_max_notify"}, {31'd0, bus.b_out_notify}, 32'd1);
        checkOutput({tag, "_max_in_notify"}, {31'd0, bus.b_in_notify}, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1);
`else
        if (expMax === 32'hxxxx_xxxx) $display("[TB] unexpected unknown max for %s", tag);
`endif
        checkOutput({tag, "_done_notify"}, {31'd0, bus.b_out_notify}, 32'd0);
        checkOutput({tag, "_done_in_notify"}, {31'd0, bus.b_in_notify}, 32'd1);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b0;
        bus.b_in       = '0;
        bus.b_in_sync  = 1'b0;
        bus.b_out_sync = 1'b0;
        #12;
        checkOutput("reset_in_notify", {31'd0, bus.b_in_notify}, 32'd1);
        checkOutput("reset_out_notify", {31'd0, bus.b_out_notify}, 32'd0);
        checkOutput("reset_b_out", bus.b_out, 32'd0);
        rst = 1'b1;

        $display("[TB] streaming frame 1..5");
        feedFrame(32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        checkSum("stream", 32'd15);
        acceptOutput("stream", 32'd5);

        $display("[TB] backpressure with ignored input pulses");
        feedFrame(32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
            checkSum("backpressure", 32'd15);
        end
        acceptOutput("backpressure", 32'd5);

        $display("[TB] signed wrap");
        feedFrame(32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0);
        checkSum("overflow", 32'h8000_0000);
        acceptOutput("overflow", 32'h7FFF_FFFF);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 32'd100, 1'b0);
        applyStimulus(1'b1, 32'd100, 1'b0);
        applyStimulus(1'b1, 32'd100, 1'b0);
        bus.b_in_sync = 1'b0;
        rst = 1'b0;
        #2;
        checkOutput("midreset_in_notify", {31'd0, bus.b_in_notify}, 32'd1);
        checkOutput("midreset_out_notify", {31'd0, bus.b_out_notify}, 32'd0);
        rst = 1'b1;
        #2;
        feedFrame(32'd1, 32'd1, 32'd1, 32'd1, 32'd1);
        checkSum("after_reset", 32'd5);
        acceptOutput("after_reset", 32'd1);

        $display("[TB] input gaps");
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i % 2) == 0, 32'd2, 1'b0);
        end
        checkOutput("gaps_not_yet", {31'd0, bus.b_out_notify}, 32'd0);
        applyStimulus(1'b1, 32'd2, 1'b0);
        checkSum("gaps", 32'd10);
        acceptOutput("gaps", 32'd2);

        $display("[TB] signed frame -3,7,2,-9,0");
        feedFrame(32'hFFFF_FFFD, 32'd7, 32'd2, 32'hFFFF_FFF7, 32'd0);
        checkSum("signed", 32'hFFFF_FFFD);
        acceptOutput("signed", 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
